// File: rtl/sram_scan_ctrl.sv
// rtl/sram_scan_ctrl.sv - address-range read/compare sequencer for the SRAM read-cycle stage
//
// Purpose:
//   On a single go_in pulse, walks START_ADDR..END_ADDR. For each address it
//   pulses rd_start_out to the read-cycle block, waits for its reading window
//   (rd_busy_in) to rise and fall, captures the returned byte and compares it
//   with addr[DATA_W-1:0] ^ seed. Scan results (error count, first failing
//   address, timeout flag, last byte) are held after done_out until the next
//   accepted go_in.
//
// Build option:
//   SCAN_STOP_ON_ERR_EN - when defined, the first mismatch ends the scan.
//                         When undefined, the whole range is always swept.
//
// Ports:
//   clk_in              in   clock
//   reset_in            in   synchronous active-high reset
//   go_in               in   start pulse, honoured only in IDLE
//   seed_in             in   pattern seed, latched at go
//   rd_start_out        out  one-cycle start pulse to the read-cycle block
//   rd_addr_out         out  address for the read-cycle block
//   rd_busy_in          in   read-cycle "reading" window
//   rd_data_in          in   read-cycle data out
//   busy_out            out  scan in progress (ISSUE through DONE)
//   done_out            out  one-cycle pulse at scan end
//   timeout_out         out  sticky: last scan aborted on rd_busy_in timeout
//   err_count_out       out  mismatch count of the last scan
//   first_err_valid_out out  at least one mismatch in the last scan
//   first_err_addr_out  out  address of the first mismatch
//   last_data_out       out  most recently captured read byte
//
// Parameters:
//   ADDR_W, DATA_W (ADDR_W >= DATA_W), START_ADDR <= END_ADDR,
//   TIMEOUT >= 2 (cycles from the start pulse to DONE when rd_busy_in never rises)

module sram_scan_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 511,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              go_in,
  input  logic [DATA_W-1:0] seed_in,
  output logic              rd_start_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic              rd_busy_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              timeout_out,
  output logic [ADDR_W:0]   err_count_out,
  output logic              first_err_valid_out,
  output logic [ADDR_W-1:0] first_err_addr_out,
  output logic [DATA_W-1:0] last_data_out
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  // The counter starts at 0 on the first WAIT_HI cycle, so hitting TIMEOUT-1
  // after increment lands DONE exactly TIMEOUT cycles after the start pulse.
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   cnt_inc;
  logic [ADDR_W:0]   err_q, err_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] last_q, last_d;

  logic [DATA_W-1:0] expected;
  logic              mismatch;
  logic              last_addr;

  assign expected  = addr_q[DATA_W-1:0] ^ seed_q;
  assign mismatch  = (last_q != expected);
  assign last_addr = (addr_q == END_A);
  assign cnt_inc   = cnt_q + TO_W'(1);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      addr_q  <= START_A;
      seed_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      to_q    <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      to_q    <= to_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    to_d    = to_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (go_in) begin
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          to_d    = 1'b0;
          seed_d  = seed_in;
          addr_d  = START_A;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        // A late-rising busy on the final allowed cycle still counts as a response.
        if (rd_busy_in) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_inc == TO_LAST) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_LO: begin
        // The read-cycle block holds d_out valid once reading drops.
        if (!rd_busy_in) begin
          last_d  = rd_data_in;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + (ADDR_W+1)'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = addr_q;
          end
        end
`ifdef SCAN_STOP_ON_ERR_EN
        if (mismatch || last_addr) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_ISSUE;
        end
`else
        if (last_addr) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_ISSUE;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs come straight from registered state, so nothing here depends
  // combinationally on the read-cycle inputs.
  assign rd_start_out        = (state_q == ST_ISSUE);
  assign rd_addr_out         = addr_q;
  assign busy_out            = (state_q != ST_IDLE);
  assign done_out            = (state_q == ST_DONE);
  assign timeout_out         = to_q;
  assign err_count_out       = err_q;
  assign first_err_valid_out = fev_q;
  assign first_err_addr_out  = fea_q;
  assign last_data_out       = last_q;

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// tb/tb_sram_scan_ctrl.sv - scoreboard bench for sram_scan_ctrl
module tb_sram_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic       rst;
  logic       a_go;
  logic [7:0] a_seed;
  logic       a_start;
  logic [8:0] a_addr;
  logic       a_busy_in;
  logic [7:0] a_data_in;
  logic       a_busy, a_done, a_to, a_fev;
  logic [9:0] a_err;
  logic [8:0] a_fea;
  logic [7:0] a_last;

  sram_scan_ctrl #(.ADDR_W(9), .DATA_W(8), .START_ADDR(0), .END_ADDR(511), .TIMEOUT(16)) u_a (
    .clk_in(clk), .reset_in(rst), .go_in(a_go), .seed_in(a_seed),
    .rd_start_out(a_start), .rd_addr_out(a_addr), .rd_busy_in(a_busy_in), .rd_data_in(a_data_in),
    .busy_out(a_busy), .done_out(a_done), .timeout_out(a_to), .err_count_out(a_err),
    .first_err_valid_out(a_fev), .first_err_addr_out(a_fea), .last_data_out(a_last)
  );

  logic       b_go;
  logic [7:0] b_seed;
  logic       b_start;
  logic [8:0] b_addr;
  logic       b_busy_in;
  logic [7:0] b_data_in;
  logic       b_busy, b_done, b_to, b_fev;
  logic [9:0] b_err;
  logic [8:0] b_fea;
  logic [7:0] b_last;

  sram_scan_ctrl #(.ADDR_W(9), .DATA_W(8), .START_ADDR(171), .END_ADDR(171), .TIMEOUT(16)) u_b (
    .clk_in(clk), .reset_in(rst), .go_in(b_go), .seed_in(b_seed),
    .rd_start_out(b_start), .rd_addr_out(b_addr), .rd_busy_in(b_busy_in), .rd_data_in(b_data_in),
    .busy_out(b_busy), .done_out(b_done), .timeout_out(b_to), .err_count_out(b_err),
    .first_err_valid_out(b_fev), .first_err_addr_out(b_fea), .last_data_out(b_last)
  );

  // Read-cycle model for instance A: mode 0 good data, 1 bit-0 faults at 0x010/0x1ff, 2 never busy.
  int         a_mode = 0;
  logic [7:0] a_seed_model = 8'h00;
  int         a_cnt = 0;

  function automatic logic [7:0] resp(input logic [8:0] a);
    logic [7:0] d;
    d = a[7:0] ^ a_seed_model;
    if (a_mode == 1 && (a == 9'h010 || a == 9'h1ff)) d[0] = ~d[0];
    return d;
  endfunction

  always @(negedge clk) begin
    if (a_cnt > 0) a_cnt--;
    if (a_start && a_mode != 2) begin
      a_cnt     = 3;
      a_data_in = resp(a_addr);
    end
    a_busy_in = (a_cnt > 0);
  end

  int b_cnt = 0;
  int b_starts = 0;
  logic [8:0] b_start_addr = '0;
  always @(negedge clk) begin
    if (b_cnt > 0) b_cnt--;
    if (b_start) begin
      b_cnt = 4;
      b_starts++;
      b_start_addr = b_addr;
    end
    b_busy_in = (b_cnt > 0);
    b_data_in = 8'hcd;
  end

  typedef struct {
    logic [9:0] err;
    logic       fev;
    logic [8:0] fea;
    logic       to;
  } res_t;

  logic [8:0] exp_addr[$];
  res_t       exp_res[$];
  res_t       mon_r;
  int         a_starts = 0;
  int         extra_starts = 0;
  int         extra_done = 0;

  always @(negedge clk) begin
    if (a_start) begin
      a_starts++;
      if (exp_addr.size() == 0) extra_starts++;
      else expect_eq("start_addr", 32'(a_addr), 32'(exp_addr.pop_front()));
    end
    if (a_done) begin
      if (exp_res.size() == 0) extra_done++;
      else begin
        mon_r = exp_res.pop_front();
        expect_eq("done_err_count", 32'(a_err), 32'(mon_r.err));
        expect_eq("done_first_err_valid", 32'(a_fev), 32'(mon_r.fev));
        expect_eq("done_first_err_addr", 32'(a_fea), 32'(mon_r.fea));
        expect_eq("done_timeout", 32'(a_to), 32'(mon_r.to));
      end
    end
  end

  task automatic start_a(input logic [7:0] s, input int n_addr, input logic [9:0] e_err,
                         input logic e_fev, input logic [8:0] e_fea, input logic e_to);
    res_t r;
    r.err = e_err; r.fev = e_fev; r.fea = e_fea; r.to = e_to;
    a_seed       = s;
    a_seed_model = s;
    a_starts     = 0;
    for (int i = 0; i < n_addr; i++) exp_addr.push_back(9'(i));
    exp_res.push_back(r);
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    expect_eq("go_busy_next", 32'(a_busy), 32'd1);
    expect_eq("go_start_next", 32'(a_start), 32'd1);
  endtask

  task automatic wait_done_a(input int budget);
    int k;
    k = 0;
    while (!a_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    expect_eq("done_within_budget", 32'(a_done), 32'd1);
  endtask

  logic [9:0] f_err;
  int         f_n;
  int         t0;
  int         k;

  initial begin
    rst = 1'b1; a_go = 1'b0; a_seed = 8'h00; b_go = 1'b0; b_seed = 8'h00;
    repeat (3) @(negedge clk);

    expect_eq("rst_a_start", 32'(a_start), 32'd0);
    expect_eq("rst_a_busy", 32'(a_busy), 32'd0);
    expect_eq("rst_a_done", 32'(a_done), 32'd0);
    expect_eq("rst_a_timeout", 32'(a_to), 32'd0);
    expect_eq("rst_a_err", 32'(a_err), 32'd0);
    expect_eq("rst_a_fev", 32'(a_fev), 32'd0);
    expect_eq("rst_a_fea", 32'(a_fea), 32'd0);
    expect_eq("rst_a_last", 32'(a_last), 32'd0);
    expect_eq("rst_a_addr", 32'(a_addr), 32'd0);
    expect_eq("rst_b_addr", 32'(b_addr), 32'h0ab);
    rst = 1'b0;
    @(negedge clk);

    // Single word at 0xab: 0xab ^ 0x66 = 0xcd, which the model returns.
    b_seed = 8'h66;
    b_go = 1'b1;
    @(negedge clk);
    b_go = 1'b0;
    expect_eq("b_go_busy", 32'(b_busy), 32'd1);
    expect_eq("b_go_start", 32'(b_start), 32'd1);
    k = 0;
    while (!b_done && k < 100) begin @(negedge clk); k++; end
    expect_eq("b_done_seen", 32'(b_done), 32'd1);
    expect_eq("b_err", 32'(b_err), 32'd0);
    expect_eq("b_fev", 32'(b_fev), 32'd0);
    expect_eq("b_last", 32'(b_last), 32'hcd);
    @(negedge clk);
    expect_eq("b_idle_after_done", 32'(b_busy), 32'd0);
    expect_eq("b_start_count", 32'(b_starts), 32'd1);
    expect_eq("b_start_addr", 32'(b_start_addr), 32'h0ab);

    // Full clean sweep.
    a_mode = 0;
    start_a(8'h5a, 512, 10'd0, 1'b0, 9'd0, 1'b0);
    wait_done_a(4000);
    expect_eq("sweep_last_data", 32'(a_last), 32'h0a5);
    @(negedge clk);
    expect_eq("sweep_start_count", 32'(a_starts), 32'd512);
    expect_eq("sweep_addr_drained", 32'(exp_addr.size()), 32'd0);
    expect_eq("sweep_idle", 32'(a_busy), 32'd0);

    // Injected faults at 0x010 and 0x1ff.
`ifdef SCAN_STOP_ON_ERR_EN
    f_err = 10'd1; f_n = 17;
`else
    f_err = 10'd2; f_n = 512;
`endif
    a_mode = 1;
    start_a(8'h3c, f_n, f_err, 1'b1, 9'h010, 1'b0);
    wait_done_a(4000);
    repeat (10) @(negedge clk);
    expect_eq("fault_start_count", 32'(a_starts), 32'(f_n));
    expect_eq("fault_err_held", 32'(a_err), 32'(f_err));

    // Timeout: model never raises busy; done lands 16 cycles after the start pulse.
    a_mode = 2;
    start_a(8'h00, 1, 10'd0, 1'b0, 9'd0, 1'b1);
    t0 = cyc;
    wait_done_a(100);
    expect_eq("timeout_latency", 32'(cyc - t0), 32'd16);
    a_go = 1'b1; a_seed = 8'hff;
    @(negedge clk);
    a_go = 1'b0;
    expect_eq("go_at_done_ignored", 32'(a_busy), 32'd0);
    expect_eq("timeout_sticky", 32'(a_to), 32'd1);
    repeat (30) @(negedge clk);

    // Reset mid-scan while address 0x080 is in WAIT_LO.
    a_mode = 0;
    start_a(8'h11, 129, 10'd0, 1'b0, 9'd0, 1'b0);
    k = 0;
    while (!(a_start && a_addr == 9'h080) && k < 2000) begin @(negedge clk); k++; end
    expect_eq("reached_addr_080", 32'(a_addr), 32'h080);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_res.delete();
    expect_eq("mid_rst_start", 32'(a_start), 32'd0);
    expect_eq("mid_rst_busy", 32'(a_busy), 32'd0);
    expect_eq("mid_rst_addr", 32'(a_addr), 32'd0);
    expect_eq("mid_rst_last", 32'(a_last), 32'd0);
    expect_eq("mid_rst_err", 32'(a_err), 32'd0);
    expect_eq("mid_rst_timeout", 32'(a_to), 32'd0);
    expect_eq("mid_rst_addr_drained", 32'(exp_addr.size()), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Restart after reset: must begin again at START_ADDR with no errors.
    start_a(8'h11, 512, 10'd0, 1'b0, 9'd0, 1'b0);
    wait_done_a(4000);
    @(negedge clk);
    expect_eq("restart_start_count", 32'(a_starts), 32'd512);

    // go_in pulsed repeatedly while busy, with a different seed each time.
    a_mode = 1;
    start_a(8'h77, f_n, f_err, 1'b1, 9'h010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      a_go = 1'b1; a_seed = 8'($urandom);
      @(negedge clk);
      a_go = 1'b0;
    end
    wait_done_a(4000);
    @(negedge clk);
    expect_eq("busy_go_start_count", 32'(a_starts), 32'(f_n));
    expect_eq("busy_go_first_err_addr", 32'(a_fea), 32'h010);

    repeat (5) @(negedge clk);
    expect_eq("extra_starts", 32'(extra_starts), 32'd0);
    expect_eq("extra_done", 32'(extra_done), 32'd0);
    expect_eq("res_queue_drained", 32'(exp_res.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
